pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter PAYLOAD_W, default 226, SHALL set the payload width in bits.
REQ-002 Parameter RST_VAL, default 0 (PAYLOAD_W bits), SHALL set the payload register reset value.
REQ-003 Parameter SKID, default 1, SHALL select the mode: 1 = two-entry skid buffer with registered in_ready, 0 = single entry with combinational in_ready.
REQ-004 Parameter CNT_W, default 16, SHALL set the stall counter width.
REQ-005 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1 bit: reset, synchronous and active-low (0 = reset).
REQ-007 Port in_valid, input, 1 bit: upstream has a payload.
REQ-008 Port in_ready, output, 1 bit: stage can accept a payload.
REQ-009 Port in_data, input, PAYLOAD_W bits: upstream payload.
REQ-010 Port out_valid, output, 1 bit: out_data holds a valid payload.
REQ-011 Port out_ready, input, 1 bit: downstream accepts the payload.
REQ-012 Port out_data, output, PAYLOAD_W bits: payload to downstream.
REQ-013 Port flush, input, 1 bit: discard all held entries.
REQ-014 Port stall_clr, input, 1 bit: clear the stall counter.
REQ-015 Port stall_cnt, output, CNT_W bits: count of back-pressured cycles.

Function
REQ-016 An input transfer SHALL occur on a cycle with in_valid=1 and in_ready=1; an output transfer on a cycle with out_valid=1 and out_ready=1.
REQ-017 The state SHALL be one of EMPTY, ONE (main register full) or TWO (main and skid full; SKID=1 only).
REQ-018 out_valid SHALL equal (state != EMPTY); out_data SHALL be driven directly from the main register, with no combinational path from in_data.
REQ-019 SKID=1: in_ready SHALL equal (state != TWO), decoded from state only, with no path from out_ready.
REQ-020 SKID=0: in_ready SHALL equal (state == EMPTY) or out_ready.
REQ-021 EMPTY with an input transfer SHALL go to ONE and load main with in_data.
REQ-022 ONE with input and output transfers together SHALL stay in ONE and load main with in_data.
REQ-023 ONE with only an input transfer SHALL go to TWO and load skid with in_data (SKID=1).
REQ-024 ONE with only an output transfer SHALL go to EMPTY.
REQ-025 TWO with an output transfer SHALL go to ONE and copy skid into main; no input is accepted in TWO.
REQ-026 Payload order SHALL be preserved; each accepted payload SHALL appear on out_data exactly once, with no duplication and no loss.
REQ-027 Latency SHALL be one cycle: data accepted in EMPTY is presented on the next cycle.
REQ-028 flush=1 SHALL force the state to EMPTY on the next edge and override any simultaneous input or output transfer; held data is discarded and data registers need not clear.
REQ-029 stall_cnt SHALL increment by 1 on each cycle with out_valid=1, out_ready=0 and flush=0, and SHALL saturate at 2^CNT_W-1.
REQ-030 stall_clr=1 SHALL set stall_cnt to 0 on the next edge, taking priority over an increment.

Reset
REQ-031 While rst=0 at a rising edge: state SHALL become EMPTY, main and skid SHALL become RST_VAL, and stall_cnt SHALL become 0.
REQ-032 After reset, out_valid=0, out_data=RST_VAL and in_ready=1 SHALL hold until the first input transfer.
REQ-033 Reset SHALL override flush, stall_clr and any transfer; a reset mid-operation SHALL discard all held payloads.

Verification
REQ-034 Streaming, SKID=1: in_valid=1 with data 1,2,3,4 and out_ready=1 -> out_data 1,2,3,4 on consecutive cycles, each one cycle after entry; in_ready stays 1.
REQ-035 Back-pressure: fill with A,B, hold out_ready=0 for 5 cycles -> state TWO, in_ready=0, out_data=A, stall_cnt=5; then out_ready=1 -> A then B, no loss.
REQ-036 Flush: state TWO, flush=1 together with in_valid=1 and out_ready=1 -> next cycle out_valid=0, in_ready=1, and neither payload is ever seen.
REQ-037 SKID=0 mode: out_ready=0 while full -> in_ready=0 in the same cycle; out_ready=1 with in_valid=1 -> same-cycle replace, sustained throughput of 1 per cycle.
REQ-038 Saturation and reset: CNT_W=4 with 20 stall cycles -> stall_cnt=15; stall_clr -> 0; rst=0 while in ONE -> out_valid=0 and out_data=RST_VAL.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with optional two-entry skid buffer.
// Order-preserving valid/ready stage with flush and a stall counter.
module pipe_stage_reg #(
    parameter int unsigned          PAYLOAD_W = 226,
    parameter logic [PAYLOAD_W-1:0] RST_VAL   = '0,
    parameter int unsigned          SKID      = 1,
    parameter int unsigned          CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    input  logic                 flush,
    input  logic                 stall_clr,
    output logic [CNT_W-1:0]     stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t               state;
    logic [PAYLOAD_W-1:0] main_q;
    logic [PAYLOAD_W-1:0] skid_q;
    logic                 in_xfer;
    logic                 out_xfer;

    // Skid mode decodes ready from state alone; the single-entry mode
    // lets a full stage accept when downstream drains it this cycle.
    generate
        if (SKID != 0) begin : g_skid
            assign in_ready = (state != TWO);
        end else begin : g_single
            assign in_ready = (state == EMPTY) || out_ready;
        end
    endgenerate

    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    // Occupancy and payload registers; flush empties without clearing data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= EMPTY;
            main_q <= RST_VAL;
            skid_q <= RST_VAL;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        main_q <= in_data;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_q <= in_data;
                    end else if (in_xfer && (SKID != 0)) begin
                        skid_q <= in_data;
                        state  <= TWO;
                    end else if (out_xfer) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        main_q <= skid_q;
                        state  <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Saturating count of cycles where downstream holds off valid data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stall_clr) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && !flush
                     && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: skid (CNT_W=4) and single-entry instances
// driven in parallel, checked against queue models and a scoreboard.
module tb_pipe_stage_reg;

    localparam logic [31:0] RV0 = 32'hDEADBEEF;
    localparam logic [31:0] RV1 = 32'h5A5A0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        flush = 1'b0;
    logic        stall_clr = 1'b0;

    logic [1:0]  ir;
    logic [1:0]  ov;
    logic [31:0] od0;
    logic [31:0] od1;
    logic [3:0]  sc0;
    logic [15:0] sc1;

    int checks = 0;
    int errors = 0;

    // Model: ordered list of payloads each stage currently holds.
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int          mcnt[2];

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .PAYLOAD_W(32), .RST_VAL(RV0), .SKID(1), .CNT_W(4)
    ) u_skid (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od0),
        .flush(flush), .stall_clr(stall_clr), .stall_cnt(sc0)
    );

    pipe_stage_reg #(
        .PAYLOAD_W(32), .RST_VAL(RV1), .SKID(0), .CNT_W(16)
    ) u_single (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od1),
        .flush(flush), .stall_clr(stall_clr), .stall_cnt(sc1)
    );

    task automatic chk(string name, int k, logic [63:0] act,
                       logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%0h required=%0h @%0t",
                     name, k, act, exp, $time);
        end
    endtask

    function automatic int qsize(int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    // Scoreboard monitor: every output transfer must match the oldest
    // accepted payload.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst && !flush && out_ready) begin
                if (ov[0]) begin
                    if (q0.size() == 0) chk("spurious_out", 0, 1, 0);
                    else begin
                        e = q0.pop_front();
                        chk("out_data", 0, od0, e);
                    end
                end
                if (ov[1]) begin
                    if (q1.size() == 0) chk("spurious_out", 1, 1, 0);
                    else begin
                        e = q1.pop_front();
                        chk("out_data", 1, od1, e);
                    end
                end
            end
        end
    end

    // One clock cycle of stimulus; entered and left at posedge+1.
    task automatic drive(input logic iv, input logic [31:0] d,
                         input logic ordy, input logic fl,
                         input logic sclr, input logic r);
        int  held[2];
        bit  exp_ir[2];
        int  cmax;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        stall_clr = sclr;
        rst       = r;
        #1;
        for (int k = 0; k < 2; k++) begin
            held[k]   = qsize(k);
            exp_ir[k] = (k == 0) ? (held[k] < 2)
                                 : (held[k] == 0 || ordy);
            chk("out_valid", k, 64'(ov[k]), 64'(held[k] != 0));
            chk("in_ready", k, 64'(ir[k]), 64'(exp_ir[k]));
            chk("stall_cnt", k, (k == 0) ? 64'(sc0) : 64'(sc1),
                64'(mcnt[k]));
        end
        if (iv && r && !fl) begin
            if (exp_ir[0]) q0.push_back(d);
            if (exp_ir[1]) q1.push_back(d);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            cmax = (k == 0) ? 15 : 65535;
            if (!r || sclr) mcnt[k] = 0;
            else if (held[k] != 0 && !ordy && !fl && mcnt[k] < cmax)
                mcnt[k]++;
        end
        if (!r || fl) begin
            q0.delete();
            q1.delete();
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_out_valid", 0, 64'(ov[0]), 0);
        chk("rst_out_valid", 1, 64'(ov[1]), 0);
        chk("rst_out_data", 0, 64'(od0), 64'(RV0));
        chk("rst_out_data", 1, 64'(od1), 64'(RV1));
        chk("rst_in_ready", 0, 64'(ir[0]), 1);
        chk("rst_in_ready", 1, 64'(ir[1]), 1);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        mcnt[0] = 0;
        mcnt[1] = 0;
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk_reset_state();
        drive(0, 0, 0, 0, 0, 1);
        chk_reset_state();

        // Streaming 1..4 with downstream always ready.
        for (int i = 1; i <= 4; i++) drive(1, 32'(i), 1, 0, 0, 1);
        drive(0, 0, 1, 0, 0, 1);

        // Back-pressure: A,B then five stalled cycles.
        a = 32'hAAAA0001;
        b = 32'hBBBB0002;
        drive(1, a, 0, 0, 0, 1);
        drive(1, b, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 1);
        chk("bp_in_ready", 0, 64'(ir[0]), 0);
        chk("bp_out_data", 0, 64'(od0), 64'(a));
        chk("bp_stall", 0, 64'(sc0), 5);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0, 1);

        // Flush while full, with input and output both offered.
        drive(1, 32'h11110001, 0, 0, 0, 1);
        drive(1, 32'h11110002, 0, 0, 0, 1);
        drive(1, 32'h11110003, 1, 1, 0, 1);
        chk("flush_out_valid", 0, 64'(ov[0]), 0);
        chk("flush_in_ready", 0, 64'(ir[0]), 1);
        for (int i = 0; i < 2; i++) drive(0, 0, 1, 0, 1, 1);

        // Saturation, clear, then reset while holding one entry.
        drive(1, 32'h22220001, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, 0, 1);
        chk("sat_stall", 0, 64'(sc0), 15);
        chk("sat_stall", 1, 64'(sc1), 20);
        drive(0, 0, 0, 0, 1, 1);
        chk("clr_stall", 0, 64'(sc0), 0);
        drive(0, 0, 0, 0, 0, 0);
        chk_reset_state();

        // Sustained single-cycle replacement.
        for (int i = 0; i < 6; i++) drive(1, 32'(100 + i), 1, 0, 0, 1);
        drive(1, 32'h33330001, 0, 0, 0, 1);
        drive(1, 32'h33330002, 0, 0, 0, 1);
        chk("full_in_ready", 1, 64'(ir[1]), 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 99) < 65), $urandom,
                  1'($urandom_range(0, 99) < 60),
                  1'($urandom_range(0, 99) < 3),
                  1'($urandom_range(0, 99) < 3),
                  1'($urandom_range(0, 199) != 0));
        end
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 0, 0, 1);
        chk("drain_empty", 0, 64'(q0.size()), 0);
        chk("drain_empty", 1, 64'(q1.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
